// File: rtl/lms_ctrl_pkg.sv
// Shared definitions for the LMS adaptation sequencer: state codes,
// step-size codes and the sample-counter width helper.
package lms_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FILL    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_ACQUIRE = 3'd4,
    ST_TRACK   = 3'd5,
    ST_FROZEN  = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  localparam logic [1:0] MU_FAST = 2'd0;  // mu = 1/4
  localparam logic [1:0] MU_SLOW = 2'd1;  // mu = 1/16

  // Width that holds the largest sample count any state has to reach.
  function automatic int unsigned cnt_width(input int unsigned timeout,
                                            input int unsigned conv_n,
                                            input int unsigned settle,
                                            input int unsigned l);
    int unsigned m;
    m = timeout;
    if (conv_n > m) m = conv_n;
    if (settle > m) m = settle;
    if (l > m)      m = l;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lms_err_window.sv
// Error-magnitude window: |e| against threshold plus saturating in/out
// run counters. The out-of-threshold (loss) run only exists when
// LMS_CTRL_LOSS_DETECT_EN is defined.
module lms_err_window
  import lms_ctrl_pkg::*;
#(
  parameter int unsigned W1     = 14,
  parameter int unsigned CONV_N = 256,
  parameter int unsigned LOSS_N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 sample_en_i,
  input  logic signed [W1-1:0] e_i,
  input  logic        [W1-1:0] thr_i,
  output logic                 conv_hit_o,
  output logic                 loss_hit_o
);

  localparam int unsigned RMAX = (CONV_N > LOSS_N) ? CONV_N : LOSS_N;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [W1-1:0] mag;
  logic          in_thr;
  logic [RW-1:0] in_run_q, in_run_d;

  // |e| fits in W1 unsigned bits, including the most negative input.
  always_comb begin
    mag    = e_i[W1-1] ? (~$unsigned(e_i) + 1'b1) : $unsigned(e_i);
    in_thr = sample_en_i && (mag < thr_i);
  end

  always_comb begin
    in_run_d = in_run_q;
    if (clr_i)
      in_run_d = '0;
    else if (sample_en_i)
      in_run_d = !in_thr ? '0 : ((in_run_q != '1) ? in_run_q + 1'b1 : in_run_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_run_q <= '0;
    else     in_run_q <= in_run_d;
  end

  assign conv_hit_o = in_thr && (32'(in_run_q) >= CONV_N - 1);

`ifdef LMS_CTRL_LOSS_DETECT_EN
  logic [RW-1:0] out_run_q, out_run_d;

  always_comb begin
    out_run_d = out_run_q;
    if (clr_i)
      out_run_d = '0;
    else if (sample_en_i)
      out_run_d = in_thr ? '0 : ((out_run_q != '1) ? out_run_q + 1'b1 : out_run_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_run_q <= '0;
    else     out_run_q <= out_run_d;
  end

  assign loss_hit_o = sample_en_i && !in_thr && (32'(out_run_q) >= LOSS_N - 1);
`else
  assign loss_hit_o = 1'b0;
`endif

endmodule

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation sequencer: IDLE/CLEAR/FILL/SETTLE/ACQUIRE/TRACK/FROZEN/FAULT.
// Optional macro LMS_CTRL_LOSS_DETECT_EN enables TRACK -> ACQUIRE on loss of lock.
module lms_adapt_ctrl
  import lms_ctrl_pkg::*;
#(
  parameter int unsigned W1      = 14,
  parameter int unsigned L       = 33,
  parameter int unsigned SETTLE  = 64,
  parameter int unsigned CONV_N  = 256,
  parameter int unsigned LOSS_N  = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sample_en,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 freeze,
  input  logic signed [W1-1:0] e_in,
  input  logic        [W1-1:0] e_thr,
  output logic                 coef_clr,
  output logic                 adapt_en,
  output logic [1:0]           mu_sel,
  output logic                 converged,
  output logic                 fault,
  output logic [2:0]           state
);

  localparam int unsigned CW = cnt_width(TIMEOUT, CONV_N, SETTLE, L);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          entry;
  logic          conv_hit, loss_hit;
  logic          coef_clr_q, coef_clr_d;
  logic          adapt_en_q, adapt_en_d;
  logic [1:0]    mu_sel_q, mu_sel_d;
  logic          converged_q, converged_d;
  logic          fault_q, fault_d;

  lms_err_window #(
    .W1     (W1),
    .CONV_N (CONV_N),
    .LOSS_N (LOSS_N)
  ) u_win (
    .clk         (clk),
    .rst         (aclr),
    .clr_i       (entry),
    .sample_en_i (sample_en),
    .e_i         (e_in),
    .thr_i       (e_thr),
    .conv_hit_o  (conv_hit),
    .loss_hit_o  (loss_hit)
  );

  // State, sample counter and registered outputs.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      coef_clr_q  <= 1'b0;
      adapt_en_q  <= 1'b0;
      mu_sel_q    <= MU_FAST;
      converged_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coef_clr_q  <= coef_clr_d;
      adapt_en_q  <= adapt_en_d;
      mu_sel_q    <= mu_sel_d;
      converged_q <= converged_d;
      fault_q     <= fault_d;
    end
  end

  // Next state and sample counter; start re-entering CLEAR counts as an entry.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_CLEAR;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_CLEAR:   state_d = ST_FILL;
        ST_FILL:    if (sample_en && (32'(cnt_q) >= L - 1)) state_d = ST_SETTLE;
        ST_SETTLE:  if (sample_en && (32'(cnt_q) >= SETTLE - 1)) state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (conv_hit)
            state_d = ST_TRACK;
          else if (sample_en && (32'(cnt_q) >= TIMEOUT - 1))
            state_d = ST_FAULT;
        end
        ST_TRACK: begin
          if (freeze)
            state_d = ST_FROZEN;
          else if (loss_hit)
            state_d = ST_ACQUIRE;
        end
        ST_FROZEN:  if (!freeze) state_d = ST_TRACK;
        ST_FAULT:   state_d = ST_FAULT;
        default:    state_d = ST_IDLE;
      endcase
    end

    entry = abort || start || (state_d != state_q);

    cnt_d = cnt_q;
    if (entry)
      cnt_d = '0;
    else if (sample_en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin
    coef_clr_d  = 1'b0;
    adapt_en_d  = 1'b0;
    mu_sel_d    = MU_FAST;
    converged_d = 1'b0;
    fault_d     = 1'b0;
    unique case (state_d)
      ST_CLEAR:   coef_clr_d = 1'b1;
      ST_ACQUIRE: adapt_en_d = 1'b1;
      ST_TRACK: begin
        adapt_en_d  = 1'b1;
        mu_sel_d    = MU_SLOW;
        converged_d = 1'b1;
      end
      ST_FROZEN: begin
        mu_sel_d    = MU_SLOW;
        converged_d = 1'b1;
      end
      ST_FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  assign coef_clr  = coef_clr_q;
  assign adapt_en  = adapt_en_q;
  assign mu_sel    = mu_sel_q;
  assign converged = converged_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Self-checking bench for lms_adapt_ctrl (SETTLE=4, CONV_N=8, LOSS_N=4,
// TIMEOUT=100, L=33). Honours LMS_CTRL_LOSS_DETECT_EN if defined.
module tb_lms_adapt_ctrl;

  localparam int W1      = 14;
  localparam int L       = 33;
  localparam int SETTLE  = 4;
  localparam int CONV_N  = 8;
  localparam int LOSS_N  = 4;
  localparam int TIMEOUT = 100;
`ifdef LMS_CTRL_LOSS_DETECT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 aclr;
  logic                 sample_en, start, abort, freeze;
  logic signed [W1-1:0] e_in;
  logic        [W1-1:0] e_thr;
  logic                 coef_clr, adapt_en, converged, fault;
  logic [1:0]           mu_sel;
  logic [2:0]           state;
  logic [8:0]           dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] sb_q[$];

  // reference model state
  int m_state, m_cnt, m_in, m_out, thr;
  bit frz;

  always #5 clk = ~clk;

  lms_adapt_ctrl #(
    .W1      (W1),
    .L       (L),
    .SETTLE  (SETTLE),
    .CONV_N  (CONV_N),
    .LOSS_N  (LOSS_N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .aclr      (aclr),
    .sample_en (sample_en),
    .start     (start),
    .abort     (abort),
    .freeze    (freeze),
    .e_in      (e_in),
    .e_thr     (e_thr),
    .coef_clr  (coef_clr),
    .adapt_en  (adapt_en),
    .mu_sel    (mu_sel),
    .converged (converged),
    .fault     (fault),
    .state     (state)
  );

  assign dut_vec = {state, coef_clr, adapt_en, mu_sel, converged, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic [2:0] s;
    s = 3'(m_state);
    return {s, (m_state == 1), (m_state == 4 || m_state == 5),
            ((m_state == 5 || m_state == 6) ? 2'd1 : 2'd0),
            (m_state == 5 || m_state == 6), (m_state == 7)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_in = 0; m_out = 0;
  endtask

  task automatic model_step(input bit se, input int e, input bit st, input bit ab, input bit fr);
    int a, ns;
    bit inthr, conv, loss, tmo, ent;
    a     = (e < 0) ? -e : e;
    inthr = se && (a < thr);
    conv  = inthr && (m_in == CONV_N - 1);
    loss  = LOSS_EN && se && !inthr && (m_out == LOSS_N - 1);
    tmo   = se && (m_cnt == TIMEOUT - 1);
    ns    = m_state;
    if (ab)      ns = 0;
    else if (st) ns = 1;
    else begin
      case (m_state)
        1: ns = 2;
        2: if (se && m_cnt == L - 1) ns = 3;
        3: if (se && m_cnt == SETTLE - 1) ns = 4;
        4: if (conv) ns = 5; else if (tmo) ns = 7;
        5: if (fr) ns = 6; else if (loss) ns = 4;
        6: if (!fr) ns = 5;
        default: ;
      endcase
    end
    ent = ab || st || (ns != m_state);
    if (ent) begin
      m_cnt = 0; m_in = 0; m_out = 0;
    end else if (se) begin
      if (m_cnt < 1000) m_cnt++;
      if (inthr) begin m_in = (m_in < 1000) ? m_in + 1 : m_in; m_out = 0; end
      else       begin m_out = (m_out < 1000) ? m_out + 1 : m_out; m_in = 0; end
    end
    m_state = ns;
  endtask

  // One clock: drive, let the edge happen, push model expectation, compare.
  task automatic cycle(input bit se, input int e, input bit st, input bit ab);
    logic [8:0] exp;
    sample_en = se; e_in = W1'(e); start = st; abort = ab; freeze = frz;
    e_thr = W1'(thr);
    @(posedge clk);
    if (aclr) model_reset();
    else      model_step(se, e, st, ab, frz);
    sb_q.push_back(model_vec());
    #1;
    exp = sb_q.pop_front();
    check_eq("cycle", dut_vec, exp);
  endtask

  task automatic strobe(input int e);
    cycle(1'b1, e, 1'b0, 1'b0);
    cycle(1'b0, e, 1'b0, 1'b0);
  endtask

  task automatic go_acquire(input int e);
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < L + SETTLE; k++) strobe(e);
    check_eq("in_acquire", state, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; sample_en = 0; start = 0; abort = 0; freeze = 0;
    e_in = '0; thr = 50; e_thr = W1'(thr); frz = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", dut_vec, 0);
    aclr = 1'b0;

    // start: CLEAR pulse, fill + settle, acquire then track
    cycle(1'b0, 0, 1'b1, 1'b0);
    check_eq("coef_clr_hi", coef_clr, 1);
    check_eq("clear_state", state, 1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check_eq("coef_clr_lo", coef_clr, 0);
    for (int k = 1; k <= L + SETTLE; k++) begin
      strobe(10);
      if (k == L + SETTLE - 1) check_eq("adapt_pre37", adapt_en, 0);
    end
    check_eq("adapt_at37", adapt_en, 1);
    check_eq("mu_fast", mu_sel, 0);
    for (int k = 1; k < CONV_N; k++) strobe(10);
    check_eq("conv_pre", state, 4);
    strobe(10);
    check_eq("track_state", state, 5);
    check_eq("track_mu", mu_sel, 1);
    check_eq("track_conv", converged, 1);

    // loss of lock
    for (int k = 0; k < LOSS_N; k++) strobe(200);
    check_eq("loss_state", state, LOSS_EN ? 4 : 5);
    check_eq("loss_conv", converged, LOSS_EN ? 0 : 1);
    for (int k = 0; k < CONV_N; k++) strobe(10);
    check_eq("retrack", state, 5);

    // freeze / unfreeze
    frz = 1;
    cycle(1'b0, 0, 1'b0, 1'b0);
    check_eq("frozen_state", state, 6);
    check_eq("frozen_adapt", adapt_en, 0);
    check_eq("frozen_conv", converged, 1);
    for (int k = 0; k < 6; k++) strobe(200);
    check_eq("frozen_hold", state, 6);
    frz = 0;
    cycle(1'b0, 0, 1'b0, 1'b0);
    check_eq("unfreeze", state, 5);
    for (int k = 0; k < LOSS_N - 1; k++) strobe(200);
    check_eq("unfreeze_hold", state, 5);

    // timeout with most negative error
    go_acquire(-8192);
    for (int k = 1; k < TIMEOUT; k++) strobe(-8192);
    check_eq("pre_timeout", state, 4);
    strobe(-8192);
    check_eq("fault_flag", fault, 1);
    check_eq("fault_adapt", adapt_en, 0);
    check_eq("fault_state", state, 7);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check_eq("restart_state", state, 1);
    check_eq("restart_fault", fault, 0);

    // alternating in/out samples never converge
    go_acquire(10);
    for (int k = 1; k <= TIMEOUT; k++) begin
      strobe((k % 2) ? 60 : 10);
      if (k == TIMEOUT - 1) check_eq("alt_pre", state, 4);
    end
    check_eq("alt_fault", state, 7);

    // zero threshold: never in-threshold
    thr = 0;
    go_acquire(0);
    for (int k = 0; k < TIMEOUT; k++) strobe(0);
    check_eq("thr0_fault", state, 7);
    thr = 50;

    // abort beats start in TRACK
    go_acquire(10);
    for (int k = 0; k < CONV_N; k++) strobe(10);
    check_eq("pre_abort", state, 5);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check_eq("abort_start", dut_vec, 0);

    // async clear during FILL
    cycle(1'b0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) strobe(10);
    check_eq("in_fill", state, 2);
    #2 aclr = 1'b1;
    #1;
    check_eq("aclr_async", dut_vec, 0);
    model_reset();
    cycle(1'b1, 10, 1'b0, 1'b0);
    aclr = 1'b0;
    cycle(1'b1, 10, 1'b0, 1'b0);

    // random traffic, back-to-back strobes allowed
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 49) == 0) frz = ~frz;
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 120)) - 60,
            ($urandom_range(0, 299) == 0), ($urandom_range(0, 599) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
